// File: rtl/systolic_pkg.sv
// Shared sizing and FSM state encoding for the systolic writeback slice.
package systolic_pkg;

  localparam int ARRAY_SIZE    = 32;
  localparam int DATA_WIDTH    = 8;
  localparam int OUTCOME_WIDTH = 2*DATA_WIDTH+5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FLUSH = 2'd2
  } wb_state_t;

endpackage

// File: rtl/systolic_requant.sv
// One lane requantizer: arithmetic shift right, optional ReLU, signed saturate.
// Purely combinational; WB_RELU_EN clamps negative results to zero.
module systolic_requant #(
  parameter int DATA_WIDTH    = systolic_pkg::DATA_WIDTH,
  parameter int OUTCOME_WIDTH = systolic_pkg::OUTCOME_WIDTH
) (
  input  logic [OUTCOME_WIDTH-1:0] lane_in,
  input  logic [3:0]               shift_amt,
  output logic [DATA_WIDTH-1:0]    lane_out
);

  localparam int MAX_I = 2**(DATA_WIDTH-1) - 1;
  localparam logic signed [OUTCOME_WIDTH-1:0] MAX_V = OUTCOME_WIDTH'(MAX_I);
  localparam logic signed [OUTCOME_WIDTH-1:0] MIN_V = OUTCOME_WIDTH'(-MAX_I - 1);

  logic signed [OUTCOME_WIDTH-1:0] shifted;
  logic signed [OUTCOME_WIDTH-1:0] clipped;

  always_comb begin
    shifted = $signed(lane_in) >>> shift_amt;
`ifdef WB_RELU_EN
    if (shifted < 0) begin
      shifted = '0;
    end
`endif
    if (shifted > MAX_V) begin
      clipped = MAX_V;
    end else if (shifted < MIN_V) begin
      clipped = MIN_V;
    end else begin
      clipped = shifted;
    end
    lane_out = clipped[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_writeback.sv
// Sweeps matrix_index 0..ARRAY_SIZE-1, requantizes each array word and writes it to SRAM;
// one word/cycle, output register stalls (index held) while sram_ready is low. WB_RELU_EN selects ReLU.
module systolic_writeback #(
  parameter int ARRAY_SIZE    = systolic_pkg::ARRAY_SIZE,
  parameter int DATA_WIDTH    = systolic_pkg::DATA_WIDTH,
  parameter int OUTCOME_WIDTH = systolic_pkg::OUTCOME_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wb_start,
  input  logic [3:0]                         shift_amt,
  output logic [5:0]                         matrix_index,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic                               sram_wen,
  input  logic                               sram_ready,
  output logic [5:0]                         sram_waddr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   sram_wdata,
  output logic                               wb_busy,
  output logic                               wb_done
);

  import systolic_pkg::*;

  wb_state_t state, state_nxt;

  logic [3:0]                       shift_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] req_word;
  logic                             accept;
  logic                             start_ok;
  logic                             capture;
  logic                             last_idx;

  // Lane 0 lands in the most significant byte of the SRAM word.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    systolic_requant #(
      .DATA_WIDTH   (DATA_WIDTH),
      .OUTCOME_WIDTH(OUTCOME_WIDTH)
    ) u_requant (
      .lane_in  (mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .shift_amt(shift_q),
      .lane_out (req_word[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign accept   = sram_wen & sram_ready;
  assign start_ok = wb_start & (state == IDLE) & ~wb_done;
  assign capture  = (state == SWEEP) & (~sram_wen | sram_ready);
  assign last_idx = (matrix_index == 6'(ARRAY_SIZE-1));
  assign wb_busy  = (state != IDLE) | wb_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SWEEP;
      SWEEP:   if (capture && last_idx) state_nxt = FLUSH;
      FLUSH:   if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      matrix_index <= '0;
      sram_wen     <= 1'b0;
      sram_waddr   <= '0;
      sram_wdata   <= '0;
      wb_done      <= 1'b0;
    end else begin
      wb_done <= (state == FLUSH) & accept;
      if (start_ok) begin
        shift_q      <= shift_amt;
        matrix_index <= '0;
      end else if (capture && !last_idx) begin
        matrix_index <= matrix_index + 6'd1;
      end
      // Refill the output register whenever it is empty or draining this cycle.
      if (capture) begin
        sram_wen   <= 1'b1;
        sram_waddr <= matrix_index;
        sram_wdata <= req_word;
      end else if (accept) begin
        sram_wen   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed, table-driven bench for systolic_writeback: requant vectors, backpressure, reset, ignored inputs.
module tb_systolic_writeback;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_start;
  logic [3:0]   shift_amt;
  logic [5:0]   matrix_index;
  logic [671:0] mul_outcome;
  logic         sram_wen;
  logic         sram_ready;
  logic [5:0]   sram_waddr;
  logic [255:0] sram_wdata;
  logic         wb_busy;
  logic         wb_done;

  systolic_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_start    (wb_start),
    .shift_amt   (shift_amt),
    .matrix_index(matrix_index),
    .mul_outcome (mul_outcome),
    .sram_wen    (sram_wen),
    .sram_ready  (sram_ready),
    .sram_waddr  (sram_waddr),
    .sram_wdata  (sram_wdata),
    .wb_busy     (wb_busy),
    .wb_done     (wb_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane_a;
    int         lane_b;
    logic [3:0] sh;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ra;
    logic [7:0] rb;
  } vec_t;

  vec_t vecs[8];

  int   errors = 0;
  int   checks = 0;
  int   lane_a_v = 0;
  int   lane_b_v = 0;
  bit   idx_mode = 1'b0;

  logic [5:0]   wr_addr[$];
  logic [255:0] wr_data[$];

  // Even lanes carry lane_a, odd lanes lane_b; idx_mode makes lane 0 = 8*matrix_index.
  always_comb begin
    logic [20:0] lane;
    mul_outcome = '0;
    for (int i = 0; i < 32; i++) begin
      lane = (i % 2 == 0) ? 21'(lane_a_v) : 21'(lane_b_v);
      if (idx_mode && i == 0) lane = {12'd0, matrix_index, 3'b000};
      mul_outcome[i*21 +: 21] = lane;
    end
  end

  always @(negedge clk) begin
    if (rst_n && sram_wen && sram_ready) begin
      wr_addr.push_back(sram_waddr);
      wr_data.push_back(sram_wdata);
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input logic [3:0] sh, input int stall_at, input bit poke, output int lat);
    int         stall_left;
    bit         stalled;
    logic [5:0] s_addr;
    logic [5:0] s_idx;
    logic [255:0] s_data;
    wr_addr.delete();
    wr_data.delete();
    lat = -1;
    stall_left = 0;
    stalled = 1'b0;
    s_addr = '0;
    s_idx = '0;
    s_data = '0;
    @(posedge clk); #1;
    wb_start = 1'b1;
    shift_amt = sh;
    @(posedge clk); #1;
    wb_start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (wb_done) begin
        lat = k;
        chk("busy_in_done_cycle", 256'(wb_busy), 256'(1));
        break;
      end
      if (!stalled && stall_at >= 0 && sram_wen && sram_waddr == 6'(stall_at)) begin
        sram_ready = 1'b0;
        s_addr = sram_waddr;
        s_idx = matrix_index;
        s_data = sram_wdata;
        stall_left = 4;
        stalled = 1'b1;
      end else if (stall_left > 0) begin
        chk("stall_hold", {sram_wen, matrix_index, sram_waddr, sram_wdata[242:0]},
            {1'b1, s_idx, s_addr, s_data[242:0]});
        stall_left--;
        if (stall_left == 0) sram_ready = 1'b1;
      end
      if (poke) begin
        wb_start  = (k >= 5 && k < 20);
        shift_amt = (k >= 5 && k < 20) ? 4'd0 : 4'd9;
      end
      @(posedge clk); #1;
    end
    wb_start = 1'b0;
    if (lat < 0) chk("done_timeout", 256'(0), 256'(1));
    @(posedge clk); #1;
    chk("busy_after_done", 256'(wb_busy), 256'(0));
  endtask

  task automatic check_writes(input string tag, input logic [7:0] ea, input logic [7:0] eb, input bit idx_lane0);
    int bad_order;
    int bad_data;
    logic [7:0] exp_b;
    logic [255:0] w;
    bad_order = 0;
    bad_data = 0;
    chk({tag, "_count"}, 256'(wr_addr.size()), 256'(32));
    for (int j = 0; j < wr_addr.size(); j++) begin
      if (wr_addr[j] != 6'(j)) bad_order++;
      w = wr_data[j];
      for (int i = 0; i < 32; i++) begin
        exp_b = (i % 2 == 0) ? ea : eb;
        if (idx_lane0 && i == 0) exp_b = 8'(j);
        if (w[255-8*i -: 8] != exp_b) bad_data++;
      end
    end
    chk({tag, "_addr_order_errs"}, 256'(bad_order), 256'(0));
    chk({tag, "_byte_errs"}, 256'(bad_data), 256'(0));
  endtask

  initial begin
    int lat;
    int saved;
    bit found;
    logic [7:0] ea;
    logic [7:0] eb;

    vecs[0] = '{1000,     1000,     4'd3,  8'h7D, 8'h7D, 8'h7D, 8'h7D};
    vecs[1] = '{100000,   -100000,  4'd0,  8'h7F, 8'h80, 8'h7F, 8'h00};
    vecs[2] = '{-9,       9,        4'd2,  8'hFD, 8'h02, 8'h00, 8'h02};
    vecs[3] = '{127,      -128,     4'd0,  8'h7F, 8'h80, 8'h7F, 8'h00};
    vecs[4] = '{128,      -129,     4'd0,  8'h7F, 8'h80, 8'h7F, 8'h00};
    vecs[5] = '{255,      -256,     4'd1,  8'h7F, 8'h80, 8'h7F, 8'h00};
    vecs[6] = '{-1,       1,        4'd4,  8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[7] = '{1048575,  -1048576, 4'd15, 8'h1F, 8'hE0, 8'h1F, 8'h00};

    rst_n = 1'b0;
    wb_start = 1'b0;
    shift_amt = 4'd0;
    sram_ready = 1'b1;
    #12;
    chk("rst_matrix_index", 256'(matrix_index), 256'(0));
    chk("rst_wen", 256'(sram_wen), 256'(0));
    chk("rst_waddr", 256'(sram_waddr), 256'(0));
    chk("rst_wdata", sram_wdata, 256'(0));
    chk("rst_busy", 256'(wb_busy), 256'(0));
    chk("rst_done", 256'(wb_done), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    // sram_ready high while idle must not produce writes
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_writes", 256'(wr_addr.size()), 256'(0));

    for (int v = 0; v < 8; v++) begin
      lane_a_v = vecs[v].lane_a;
      lane_b_v = vecs[v].lane_b;
`ifdef WB_RELU_EN
      ea = vecs[v].ra;
      eb = vecs[v].rb;
`else
      ea = vecs[v].ea;
      eb = vecs[v].eb;
`endif
      run_sweep(vecs[v].sh, -1, 1'b0, lat);
      chk($sformatf("vec%0d_latency", v), 256'(lat), 256'(34));
      check_writes($sformatf("vec%0d", v), ea, eb, 1'b0);
    end

    // Backpressure on address 3, lane 0 tracks the index so data/address pairing is visible.
    lane_a_v = 1000;
    lane_b_v = 1000;
    idx_mode = 1'b1;
    run_sweep(4'd3, 3, 1'b0, lat);
    chk("bp_latency", 256'(lat), 256'(38));
    check_writes("bp", 8'h7D, 8'h7D, 1'b1);
    idx_mode = 1'b0;

    // Reset while address 10 is pending.
    wr_addr.delete();
    wr_data.delete();
    @(posedge clk); #1;
    wb_start = 1'b1;
    shift_amt = 4'd3;
    @(posedge clk); #1;
    wb_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sram_wen && sram_waddr == 6'd10) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_addr10", 256'(found), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {wb_busy, wb_done, sram_wen, matrix_index, sram_waddr, sram_wdata[239:0]}, 256'(0));
    saved = wr_addr.size();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_more_writes", 256'(wr_addr.size()), 256'(saved));
    chk("midrst_idle", 256'(wb_busy), 256'(0));
    run_sweep(4'd3, -1, 1'b0, lat);
    chk("restart_latency", 256'(lat), 256'(34));
    check_writes("restart", 8'h7D, 8'h7D, 1'b0);

    // wb_start and shift_amt toggled while busy must be ignored.
    run_sweep(4'd3, -1, 1'b1, lat);
    chk("ignore_latency", 256'(lat), 256'(34));
    check_writes("ignore", 8'h7D, 8'h7D, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("ignore_no_second_sweep", 256'(wr_addr.size()), 256'(32));
    chk("ignore_idle", 256'(wb_busy), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_writeback.md
SYSTOLIC_WRITEBACK -- requirements
Module: systolic_writeback

Interface
REQ-001 Parameters SHALL be one per line:
- ARRAY_SIZE, default 32: lanes per word and sweep length.
- DATA_WIDTH, default 8: requantized element width.
- OUTCOME_WIDTH, default 21: input lane width, 2*DATA_WIDTH+5.
REQ-002 Ports SHALL be, one per line, as name direction width meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_start  in  1  single-cycle sweep request.
- shift_amt  in  4  right-shift amount, sampled with wb_start.
- matrix_index  out  6  diagonal-pair index driven to the array.
- mul_outcome  in  ARRAY_SIZE*OUTCOME_WIDTH  combinational array result for matrix_index; lane i at [i*OUTCOME_WIDTH +: OUTCOME_WIDTH].
- sram_wen  out  1  write valid.
- sram_ready  in  1  write accept.
- sram_waddr  out  6  write address.
- sram_wdata  out  ARRAY_SIZE*DATA_WIDTH  packed bytes; lane i at [255-8i -: 8].
- wb_busy  out  1  sweep in progress.
- wb_done  out  1  single-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, SWEEP and FLUSH.
- IDLE->SWEEP on wb_start.
- SWEEP->FLUSH after index 31 is captured.
- FLUSH->IDLE when the last word is accepted; wb_done pulses the cycle after that acceptance.
REQ-004 In SWEEP, matrix_index SHALL step 0..31, one value per capture; it SHALL NOT exceed 31.
REQ-005 Capture SHALL occur at the clock edge where matrix_index is valid and the output register is empty or being accepted the same cycle; the captured word goes to sram_wdata/sram_waddr=matrix_index with sram_wen=1 next cycle.
REQ-006 A write SHALL transfer only when sram_wen=1 and sram_ready=1; sram_ready while sram_wen=0 SHALL have no effect.
REQ-007 When sram_wen=1 and sram_ready=0, sram_wen, sram_waddr, sram_wdata and matrix_index SHALL be held stable.
REQ-008 Addresses SHALL be written exactly once each, in order 0..31, with no gaps or duplicates.
REQ-009 With sram_ready held high, throughput SHALL be one word per cycle, and wb_done SHALL assert 34 cycles after the wb_start cycle.
REQ-010 Per-lane requantization SHALL be:
- y = lane value arithmetic-shifted right by shift_amt (floor);
- then saturated to [-128,127];
- then truncated to DATA_WIDTH.
REQ-011 shift_amt SHALL be latched at wb_start; changes during a sweep SHALL be ignored.
REQ-012 wb_start while wb_busy=1 SHALL be ignored.
REQ-013 wb_busy SHALL be 1 from the cycle after accepted wb_start through the cycle wb_done asserts.

Reset
REQ-014 rst_n low SHALL immediately force:
- state IDLE;
- matrix_index=0, sram_wen=0, sram_waddr=0, sram_wdata=0;
- wb_busy=0, wb_done=0;
- latched shift=0.
REQ-015 Reset mid-sweep SHALL abandon the sweep with no further writes; the next wb_start restarts at address 0.

Configuration
REQ-016 With WB_RELU_EN defined, negative shifted values SHALL become 0 before saturation. Without WB_RELU_EN, the signed saturation of REQ-010 SHALL apply unchanged.

Structure
REQ-017 Package systolic_pkg SHALL hold ARRAY_SIZE, DATA_WIDTH, OUTCOME_WIDTH and the FSM state typedef.
REQ-018 Sub-module systolic_requant SHALL implement one lane (shift, optional ReLU, saturate) and be instantiated ARRAY_SIZE times.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Basic sweep: all lanes 1000, shift_amt=3, ready high -> 32 writes, addr 0..31 back-to-back, every byte 0x7D, wb_done at cycle 34.
- Saturation: lane 100000 and lane -100000, shift 0 -> 0x7F and 0x80; with WB_RELU_EN -> 0x7F and 0x00.
- Floor shift: lane -9, shift 2 -> 0xFD; lane 9 -> 0x02.
- Backpressure: ready low while addr 3 pending for 4 cycles -> addr/data/matrix_index stable; sequence still 0..31 with no duplicates.
- Reset and ignored inputs: rst_n low at addr 10 -> outputs 0 same cycle, next start writes from addr 0; wb_start and shift_amt changes during busy -> no effect.
